// File: rtl/tagger_formatter.sv
// Timestamping tag formatter: captures masked per-channel edges, buffers them as
// entries in a FIFO and serialises each entry into 32-bit host words.
module tagger_formatter #(
  parameter int CHANNELS        = 8,
  parameter int BITS            = 4,
  parameter int COUNTER_WIDTH   = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BITS*CHANNELS-1:0]     in_subtimes,
  input  logic [CHANNELS-1:0]          in_edge_detected,
  input  logic [CHANNELS-1:0]          channel_enable,
  input  logic                         write_full,
  output logic                         write_enable,
  output logic [31:0]                  write_data,
  output logic [FIFO_DEPTH_LOG2:0]     fifo_level,
  output logic                         overflow_active
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OVF  = 2'd1,
    ROLL = 2'd2,
    TAGS = 2'd3
  } state_t;

  typedef struct packed {
    logic [CHANNELS-1:0]      edges;
    logic [BITS*CHANNELS-1:0] subs;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic                     roll;
    logic                     ovf;
    logic [15:0]              lost;
  } entry_t;

  logic [COUNTER_WIDTH-1:0]   r_cnt;
  logic                       r_started;
  logic [CHANNELS-1:0]        r_cap_edges;
  logic [BITS*CHANNELS-1:0]   r_cap_subs;
  logic [COUNTER_WIDTH-1:0]   r_cap_cnt;
  logic                       r_cap_roll;

  entry_t                     r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic [15:0]                r_lost;

  state_t                     r_state;
  entry_t                     r_cur;
  logic [23:0]                r_roll_cnt;

  logic                       w_push;
  logic                       w_full;
  logic                       w_accept;
  logic                       w_drop;
  logic                       w_pop;
  entry_t                     w_entry;

  entry_t                     w_src;
  entry_t                     w_rem;
  state_t                     w_kind;
  state_t                     w_next;
  logic                       w_have;
  logic                       w_fire;
  logic [5:0]                 w_ch;
  logic [BITS-1:0]            w_sub;
  logic [CHANNELS-1:0]        w_low;

  // r_started masks the counter's zero right after reset so it is not a rollover
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_started   <= 1'b0;
      r_cap_edges <= '0;
      r_cap_subs  <= '0;
      r_cap_cnt   <= '0;
      r_cap_roll  <= 1'b0;
    end else begin
      r_cnt       <= r_cnt + 1'b1;
      r_started   <= 1'b1;
      r_cap_edges <= in_edge_detected & channel_enable;
      r_cap_subs  <= in_subtimes;
      r_cap_cnt   <= r_cnt;
      r_cap_roll  <= r_started && (r_cnt == '0);
    end
  end

  always_comb begin
    w_push       = (|r_cap_edges) || r_cap_roll;
    w_full       = (r_count == (FIFO_DEPTH_LOG2+1)'(DEPTH));
    w_accept     = w_push && (!w_full || w_pop);
    w_drop       = w_push && w_full && !w_pop;
    w_entry      = '0;
    w_entry.edges = r_cap_edges;
    w_entry.subs  = r_cap_subs;
    w_entry.cnt   = r_cap_cnt;
    w_entry.roll  = r_cap_roll;
    w_entry.ovf   = (r_lost != '0);
    w_entry.lost  = r_lost;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_lost  <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_accept)
        r_lost <= '0;
      else if (w_drop && (r_lost != '1))
        r_lost <= r_lost + 1'b1;
    end
  end

  // FSM state register; r_cur holds what is left of the popped entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_roll_cnt <= '0;
    end else if (w_fire) begin
      r_state <= w_next;
      r_cur   <= w_rem;
      if (w_kind == ROLL) r_roll_cnt <= r_roll_cnt + 24'd1;
    end
  end

  // IDLE emits the head entry's first word in the same cycle it pops, which
  // keeps capture-to-write latency at two cycles and throughput at one word/cycle.
  always_comb begin
    w_src  = (r_state == IDLE) ? r_mem[r_rptr] : r_cur;
    w_have = (r_state != IDLE) || (r_count != '0);
    w_fire = w_have && !write_full;
    w_pop  = w_fire && (r_state == IDLE);

    w_ch  = '0;
    w_sub = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (w_src.edges[i-1]) begin
        w_ch  = 6'(i - 1);
        w_sub = w_src.subs[(i-1)*BITS +: BITS];
      end
    end
    w_low = w_src.edges & (~w_src.edges + 1'b1);

    if (r_state != IDLE) w_kind = r_state;
    else if (w_src.ovf)  w_kind = OVF;
    else if (w_src.roll) w_kind = ROLL;
    else                 w_kind = TAGS;

    w_rem = w_src;
    case (w_kind)
      OVF:     w_rem.ovf   = 1'b0;
      ROLL:    w_rem.roll  = 1'b0;
      TAGS:    w_rem.edges = w_src.edges & ~w_low;
      default: ;
    endcase

    if (w_rem.ovf)         w_next = OVF;
    else if (w_rem.roll)   w_next = ROLL;
    else if (|w_rem.edges) w_next = TAGS;
    else                   w_next = IDLE;
  end

  always_comb begin
    write_enable    = w_fire;
    fifo_level      = r_count;
    overflow_active = (r_lost != '0);
    write_data      = '0;
    if (w_have) begin
      case (w_kind)
        OVF:  write_data = {2'b10, 14'd0, w_src.lost};
        ROLL: write_data = {2'b01, 6'd0, r_roll_cnt + 24'd1};
        default: begin
          write_data[29:24]                = w_ch;
          write_data[BITS +: COUNTER_WIDTH] = w_src.cnt;
          write_data[BITS-1:0]             = w_sub;
        end
      endcase
    end
  end

endmodule
